sel_encode_seq: RTL and testbench

// Parametrised select-and-encode unit for the datapath register file. Latches the IR
// and decodes its Ra/Rb/Rc fields into one-hot Rin/Rout enables and a sign-extended
// C constant. Supports manual Gra/Grb/Grc control from the control unit, plus a

---
 rtl/sel_encode_seq.sv | 136 +++++++++++++
 tb/tb_sel_encode_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sel_encode_seq.sv
// Register-file select/encode unit: latches the IR, decodes Ra/Rb/Rc into one-hot
// read/write enables, and runs a small Rb -> Rc/imm -> ALU wait -> Ra operand sequencer.
module sel_encode_seq #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 16,
  parameter int REG_ADDR_W = 4,
  parameter int RA_LSB     = 23,
  parameter int RB_LSB     = 19,
  parameter int RC_LSB     = 15,
  parameter int IMM_W      = 19
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_W-1:0]    ir,
  input  logic                 ir_load,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  input  logic                 ba_out,
  input  logic                 seq_start,
  input  logic                 seq_imm,
  input  logic                 alu_done,
  output logic [REG_COUNT-1:0] rin_arr,
  output logic [REG_COUNT-1:0] rout_arr,
  output logic                 bus_zero,
  output logic                 c_out,
  output logic [DATA_W-1:0]    c_sign_ext,
  output logic                 seq_busy,
  output logic                 seq_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_B = 3'd1;
  localparam logic [2:0] S_RD_C = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_WR_A = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [DATA_W-1:0]     r_ir;
  logic                  r_imm;
  logic                  r_done;
  logic [REG_ADDR_W-1:0] w_ra;
  logic [REG_ADDR_W-1:0] w_rb;
  logic [REG_ADDR_W-1:0] w_rc;
  logic [REG_ADDR_W-1:0] w_sel;
  logic                  w_sel_vld;
  logic                  w_bz;

  // Field values at or above REG_COUNT never match, so they assert no enable.
  function automatic logic [REG_COUNT-1:0] onehot(input logic [REG_ADDR_W-1:0] f,
                                                  input logic en);
    logic [REG_COUNT-1:0] v;
    v = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (en && (f == REG_ADDR_W'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign w_ra       = r_ir[RA_LSB +: REG_ADDR_W];
  assign w_rb       = r_ir[RB_LSB +: REG_ADDR_W];
  assign w_rc       = r_ir[RC_LSB +: REG_ADDR_W];
  assign c_sign_ext = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
  assign seq_busy   = (r_state != S_IDLE);
  assign seq_done   = r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (seq_start) w_next = S_RD_B; else w_next = S_IDLE;
      S_RD_B:  w_next = S_RD_C;
      S_RD_C:  w_next = S_WAIT;
      S_WAIT:  if (alu_done) w_next = S_WR_A; else w_next = S_WAIT;
      S_WR_A:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // IR is frozen while the sequencer runs; imm selection is captured at start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_imm   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_WR_A);
      if ((r_state == S_IDLE) && ir_load) r_ir <= ir;
      if ((r_state == S_IDLE) && seq_start) r_imm <= seq_imm;
    end
  end

  always_comb begin
    rin_arr   = '0;
    rout_arr  = '0;
    bus_zero  = 1'b0;
    c_out     = 1'b0;
    w_sel     = '0;
    w_sel_vld = 1'b0;
    w_bz      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (gra) begin
          w_sel = w_ra; w_sel_vld = 1'b1;
        end else if (grb) begin
          w_sel = w_rb; w_sel_vld = 1'b1;
        end else if (grc) begin
          w_sel = w_rc; w_sel_vld = 1'b1;
        end else begin
          w_sel = '0; w_sel_vld = 1'b0;
        end
        // Base-address read of R0 yields a zero bus rather than R0's contents.
        w_bz     = w_sel_vld & ba_out & (w_sel == '0);
        bus_zero = w_bz;
        rin_arr  = onehot(w_sel, w_sel_vld & rin);
        rout_arr = onehot(w_sel, w_sel_vld & (rout | ba_out) & ~w_bz);
      end
      S_RD_B: rout_arr = onehot(w_rb, 1'b1);
      S_RD_C: begin
        if (r_imm) c_out = 1'b1;
        else       rout_arr = onehot(w_rc, 1'b1);
      end
      S_WAIT: rin_arr = '0;
      S_WR_A: rin_arr = onehot(w_ra, 1'b1);
      default: begin
        rin_arr  = '0;
        rout_arr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sel_encode_seq.sv
// Scoreboard bench for sel_encode_seq: per-cycle expected outputs are queued when
// stimulus is driven and compared at the following falling edge.
module tb_sel_encode_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        ir_load = 1'b0, gra = 1'b0, grb = 1'b0, grc = 1'b0;
  logic        rin = 1'b0, rout = 1'b0, ba_out = 1'b0;
  logic        seq_start = 1'b0, seq_imm = 1'b0, alu_done = 1'b0;
  logic [15:0] rin_arr, rout_arr;
  logic        bus_zero, c_out, seq_busy, seq_done;
  logic [31:0] c_sign_ext;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];
  logic [31:0] sbc[$];

  localparam logic [31:0] IR_SEQ = 32'h01BC_8000; // Ra=3 Rb=7 Rc=9, imm=0x48000

  sel_encode_seq dut (
    .clock(clock), .reset_n(reset_n), .ir(ir), .ir_load(ir_load),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
    .seq_start(seq_start), .seq_imm(seq_imm), .alu_done(alu_done),
    .rin_arr(rin_arr), .rout_arr(rout_arr), .bus_zero(bus_zero), .c_out(c_out),
    .c_sign_ext(c_sign_ext), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    ir_load = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    ba_out = 1'b0; seq_start = 1'b0; seq_imm = 1'b0; alu_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] got, exp;
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    sb.push_back(36'h0);
    @(negedge clock);
    got = {rin_arr, rout_arr, c_out, bus_zero, seq_busy, seq_done};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", got, exp);
    end
    checks++;
    if (c_sign_ext !== 32'h0) begin
      errors++; $display("FAIL reset_cse got %h exp %h", c_sign_ext, 32'h0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [35:0] got, exp;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      clear_inputs();
      case (k)
        0:  begin ir_load = 1'b1; ir = 32'h0100_0000; exp = 36'h0; end
        1:  begin gra = 1'b1; rin = 1'b1; exp = {16'h0004, 16'h0000, 4'h0}; end
        2:  begin grb = 1'b1; rout = 1'b1; exp = {16'h0000, 16'h0001, 4'h0}; end
        3:  begin gra = 1'b1; grb = 1'b1; rout = 1'b1; exp = {16'h0000, 16'h0004, 4'h0}; end
        4:  begin grc = 1'b1; rin = 1'b1; rout = 1'b1; exp = {16'h0001, 16'h0001, 4'h0}; end
        5:  begin rin = 1'b1; rout = 1'b1; exp = 36'h0; end
        6:  begin ir_load = 1'b1; ir = 32'h0; gra = 1'b1; ba_out = 1'b1;
                  exp = {16'h0000, 16'h0004, 4'h0}; end
        7:  begin gra = 1'b1; ba_out = 1'b1; exp = {16'h0000, 16'h0000, 4'b0100}; end
        8:  begin ir_load = 1'b1; ir = 32'h0280_0000; gra = 1'b1; ba_out = 1'b1;
                  exp = {16'h0000, 16'h0000, 4'b0100}; end
        9:  begin gra = 1'b1; ba_out = 1'b1; exp = {16'h0000, 16'h0020, 4'h0}; end
        10: begin ir_load = 1'b1; ir = 32'h0004_8000; exp = 36'h0; end
        11: begin grc = 1'b1; rout = 1'b1; exp = {16'h0000, 16'h0200, 4'h0}; end
        default: exp = 36'h0;
      endcase
      sb.push_back(exp);
      @(negedge clock);
      got = {rin_arr, rout_arr, c_out, bus_zero, seq_busy, seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL manual step %0d got %h exp %h", k, got, exp);
      end
    end
  endtask

  task automatic test_sign_ext();
    logic [31:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      clear_inputs();
      ir_load = 1'b1;
      ir = (k == 0) ? 32'h0004_0005 : 32'h0003_FFFF;
      sbc.push_back((k == 0) ? 32'hFFFC_0005 : 32'h0003_FFFF);
      @(posedge clock); #1;
      ir_load = 1'b0;
      @(negedge clock);
      got = c_sign_ext;
      exp = sbc.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL sign_ext %0d got %h exp %h", k, got, exp);
      end
    end
  endtask

  // Step 0 loads IR_SEQ and starts in the same cycle; later ir_load/seq_start/alu_done
  // pulses land in states where they must be ignored.
  task automatic test_seq(input logic imm);
    logic [35:0] got, exp;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      clear_inputs();
      ir_load   = (k == 0) || (k == 1);
      ir        = (k == 0) ? IR_SEQ : 32'hFFFF_FFFF;
      seq_start = (k == 0) || (k == 2) || (k == 6);
      seq_imm   = (k == 0) ? imm : ~imm;
      alu_done  = (k == 1) || (k == 2) || (k == 5);
      gra       = imm && (k >= 1) && (k <= 5);
      rin       = imm && (k >= 1) && (k <= 5);
      case (k)
        1:       exp = {16'h0000, 16'h0080, 4'b0010};
        2:       exp = imm ? {16'h0000, 16'h0000, 4'b1010} : {16'h0000, 16'h0200, 4'b0010};
        3, 4, 5: exp = {16'h0000, 16'h0000, 4'b0010};
        6:       exp = {16'h0008, 16'h0000, 4'b0011};
        default: exp = 36'h0;
      endcase
      sb.push_back(exp);
      @(negedge clock);
      got = {rin_arr, rout_arr, c_out, bus_zero, seq_busy, seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL seq imm=%0d step %0d got %h exp %h", imm, k, got, exp);
      end
    end
    checks++;
    if (c_sign_ext !== 32'hFFFC_8000) begin
      errors++; $display("FAIL seq_ir_frozen got %h exp %h", c_sign_ext, 32'hFFFC_8000);
    end
  endtask

  task automatic test_reset_mid_seq();
    logic [35:0] got, exp;
    @(posedge clock); #1;
    clear_inputs();
    ir_load = 1'b1; ir = IR_SEQ; seq_start = 1'b1;
    @(posedge clock); #1;
    clear_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock); #2;
    reset_n = 1'b0;
    sb.push_back(36'h0);
    #1;
    got = {rin_arr, rout_arr, c_out, bus_zero, seq_busy, seq_done};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL async_reset got %h exp %h", got, exp);
    end
    checks++;
    if (c_sign_ext !== 32'h0) begin
      errors++; $display("FAIL async_reset_ir got %h exp %h", c_sign_ext, 32'h0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      alu_done = 1'b1;
      sb.push_back(36'h0);
      @(negedge clock);
      got = {rin_arr, rout_arr, c_out, bus_zero, seq_busy, seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL post_reset_alu %0d got %h exp %h", k, got, exp);
      end
    end
    alu_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_sign_ext();
    test_seq(1'b0);
    test_seq(1'b1);
    test_reset_mid_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
